pipe_stage_elastic: RTL

- Parametrised successor to the fixed ID/EX-style pipeline register.
- Carries an opaque payload of DATA_W bits between two core pipeline stages using a valid/ready handshake instead of a global stall line.
- A 2-entry (main + skid) buffer gives full throughput with registered in_ready_o, which breaks the combinational back-pressure path.
- flush_i kills all held entries and drives a configurable bubble payload.

---
 rtl/pipe_stage_elastic.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic 2-entry (main + skid) pipeline register with flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt_o back-pressure counter.
module pipe_stage_elastic #(
   parameter int unsigned       DATA_W = 64,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occ_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_ready_q, in_ready_d;
   logic              in_fire, out_fire;

   // in_ready is its own flop so upstream never sees a path from out_ready_i
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = (state_q != EMPTY);
   assign out_data_o  = main_data_q;
   assign occ_o       = state_q;

   assign in_fire  = in_valid_i & in_ready_q;
   assign out_fire = out_valid_o & out_ready_i;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      if (flush_i) begin
         state_d     = EMPTY;
         main_data_d = BUBBLE;
         skid_data_d = BUBBLE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d     = ONE;
                  main_data_d = in_data_i;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_data_d = in_data_i;
               end else if (in_fire) begin
                  state_d     = FULL;
                  skid_data_d = in_data_i;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d     = ONE;
                  main_data_d = skid_data_q;
                  skid_data_d = BUBBLE;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_data_q <= BUBBLE;
         skid_data_q <= BUBBLE;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
         in_ready_q  <= in_ready_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // flush deliberately leaves the counter alone; only reset clears it
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_o && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
